// File: rtl/mult_seq_controller_taint_if.sv
// Control/status bundle between the taint-tracked multiplier controller and its
// requester/datapath. The optional abort pair exists only with MULT_CTRL_ABORT_EN.
`timescale 1ns/1ps
interface mult_seq_controller_taint_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] multiplierReg;
    logic [WIDTH-1:0] multiplierReg_t;
`ifdef MULT_CTRL_ABORT_EN
    logic             abort;
    logic             abort_t;
`endif
    logic mrld,    mdld,    rsclear,    rsload,    rsshr;
    logic mrld_t,  mdld_t,  rsclear_t,  rsload_t,  rsshr_t;
    logic busy,    busy_t,  done,       done_t;

    // Requester/datapath side
    modport master (
        output start, start_t, multiplierReg, multiplierReg_t,
`ifdef MULT_CTRL_ABORT_EN
        output abort, abort_t,
`endif
        input  mrld, mdld, rsclear, rsload, rsshr,
        input  mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        input  busy, busy_t, done, done_t
    );

    // Controller side
    modport slave (
        input  start, start_t, multiplierReg, multiplierReg_t,
`ifdef MULT_CTRL_ABORT_EN
        input  abort, abort_t,
`endif
        output mrld, mdld, rsclear, rsload, rsshr,
        output mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        output busy, busy_t, done, done_t
    );
endinterface

// File: rtl/mult_seq_controller_taint.sv
// Shift-add multiplier control FSM with control-flow taint on every strobe.
// Optional abort input enabled by defining MULT_CTRL_ABORT_EN.
`timescale 1ns/1ps
module mult_seq_controller_taint #(
    parameter int unsigned WIDTH = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    mult_seq_controller_taint_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic            r_st_t,  w_st_t_nxt;

    // State, iteration counter and sticky control taint
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_st_t  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_st_t  <= w_st_t_nxt;
        end
    end

    // Next-state logic; abort overrides the normal sequence while operating
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_st_t_nxt  = r_st_t;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                    w_st_t_nxt  = bus.start_t;
                end
            end
            S_LOAD:  w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_state_nxt = S_ADD;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
`ifdef MULT_CTRL_ABORT_EN
        if (bus.abort && (r_state == S_LOAD || r_state == S_ADD || r_state == S_SHIFT)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_st_t_nxt  = r_st_t | bus.abort_t;
        end
`endif
    end

    // Strobe decode; rsload_t carries st_t even when the add is skipped
    always_comb begin
        bus.mrld      = 1'b0;
        bus.mdld      = 1'b0;
        bus.rsclear   = 1'b0;
        bus.rsload    = 1'b0;
        bus.rsshr     = 1'b0;
        bus.mrld_t    = 1'b0;
        bus.mdld_t    = 1'b0;
        bus.rsclear_t = 1'b0;
        bus.rsload_t  = 1'b0;
        bus.rsshr_t   = 1'b0;
        bus.done      = 1'b0;
        bus.done_t    = 1'b0;
        bus.busy      = (r_state != S_IDLE);
        bus.busy_t    = (r_state != S_IDLE) & r_st_t;
        case (r_state)
            S_LOAD: begin
                bus.mrld      = 1'b1;
                bus.mdld      = 1'b1;
                bus.rsclear   = 1'b1;
                bus.mrld_t    = r_st_t;
                bus.mdld_t    = r_st_t;
                bus.rsclear_t = r_st_t;
            end
            S_ADD: begin
                bus.rsload    = bus.multiplierReg[r_cnt];
                bus.rsload_t  = r_st_t | bus.multiplierReg_t[r_cnt];
            end
            S_SHIFT: begin
                bus.rsshr     = 1'b1;
                bus.rsshr_t   = r_st_t;
            end
            S_DONE: begin
                bus.done      = 1'b1;
                bus.done_t    = r_st_t;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mult_seq_controller_taint.sv
// Directed bench for mult_seq_controller_taint with a small shift-add datapath model.
`timescale 1ns/1ps
module tb_mult_seq_controller_taint;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mult_seq_controller_taint_if #(.WIDTH(W)) bus ();

    mult_seq_controller_taint #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: static multiplier reg, (2W+1)-bit result shift register
    logic [W-1:0]   op_mr, op_mr_t, op_md;
    logic [W-1:0]   dp_mr, dp_mr_t, dp_md;
    logic [2*W:0]   dp_rs;
    logic [2*W-1:0] dp_pt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_mr <= '0; dp_mr_t <= '0; dp_md <= '0; dp_rs <= '0; dp_pt <= '0;
        end else begin
            if (bus.mrld) begin
                dp_mr   <= op_mr;
                dp_mr_t <= op_mr_t | {W{bus.mrld_t}};
            end
            if (bus.mdld) dp_md <= op_md;
            if (bus.rsclear) begin
                dp_rs <= '0;
                dp_pt <= {(2*W){bus.rsclear_t}};
            end else if (bus.rsload) begin
                dp_rs[2*W:W] <= {1'b0, dp_rs[2*W-1:W]} + {1'b0, dp_md};
                dp_pt <= dp_pt | {(2*W){bus.rsload_t}};
            end else if (bus.rsshr) begin
                dp_rs <= dp_rs >> 1;
                dp_pt <= (dp_pt >> 1) | {bus.rsshr_t, {(2*W-1){1'b0}}};
            end else if (bus.rsload_t) begin
                dp_pt <= dp_pt | {(2*W){1'b1}};
            end
        end
    end

    assign bus.multiplierReg   = dp_mr;
    assign bus.multiplierReg_t = dp_mr_t;

    function automatic logic [13:0] all_outs();
        return {bus.mrld, bus.mdld, bus.rsclear, bus.rsload, bus.rsshr,
                bus.mrld_t, bus.mdld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t,
                bus.busy, bus.busy_t, bus.done, bus.done_t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One start pulse, then observe 14 cycles; c counts cycles after the start edge
    task automatic run_op(input logic stt, output int lat, output int ndone, output int nadd,
                          output logic [3:0] ld, output logic [3:0] ldt, output int bad);
        logic is_add;
        lat = -1; ndone = 0; nadd = 0; ld = '0; ldt = '0; bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.start_t = stt;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.start_t = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            is_add = bus.busy & ~bus.mrld & ~bus.rsshr & ~bus.done;
            if (is_add) begin
                if (nadd < 4) begin
                    ld[2'(nadd)]  = bus.rsload;
                    ldt[2'(nadd)] = bus.rsload_t;
                end
                nadd++;
            end else if (bus.rsload || bus.rsload_t) bad++;
            if (bus.mrld_t    !== (bus.mrld    & stt)) bad++;
            if (bus.mdld_t    !== (bus.mdld    & stt)) bad++;
            if (bus.rsclear_t !== (bus.rsclear & stt)) bad++;
            if (bus.rsshr_t   !== (bus.rsshr   & stt)) bad++;
            if (bus.busy_t    !== (bus.busy    & stt)) bad++;
            if (bus.done_t    !== (bus.done    & stt)) bad++;
            if (bus.mdld !== bus.mrld || bus.rsclear !== bus.mrld) bad++;
            if (int'(bus.mrld) + int'(bus.rsload) + int'(bus.rsshr) + int'(bus.done) > 1) bad++;
            if (bus.done && !bus.busy) bad++;
        end
    endtask

    int         lat, ndone, nadd, bad;
    logic [3:0] ld, ldt;
    int         d1, d2, nld;
    logic       ld12;

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.start_t = 1'b0;
`ifdef MULT_CTRL_ABORT_EN
        bus.abort = 1'b0; bus.abort_t = 1'b0;
`endif
        op_mr = 4'd5; op_mr_t = 4'd0; op_md = 4'd3;

        // Reset values, during and just after reset
        #12;
        chk("outs_in_reset", 32'(all_outs()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("outs_after_release", 32'(all_outs()), 32'd0);

        // 5 x 3, untainted
        run_op(1'b0, lat, ndone, nadd, ld, ldt, bad);
        chk("t1_latency", 32'(lat), 32'd10);
        chk("t1_done_count", 32'(ndone), 32'd1);
        chk("t1_add_iters", 32'(nadd), 32'd4);
        chk("t1_rsload_mask", 32'(ld), 32'h5);
        chk("t1_rsload_t_mask", 32'(ldt), 32'h0);
        chk("t1_taint_rules", 32'(bad), 32'd0);
        chk("t1_product", 32'(dp_rs[2*W-1:0]), 32'd15);
        chk("t1_product_t", 32'(dp_pt), 32'd0);

        // 5 x 3, tainted start
        run_op(1'b1, lat, ndone, nadd, ld, ldt, bad);
        chk("t2_latency", 32'(lat), 32'd10);
        chk("t2_rsload_mask", 32'(ld), 32'h5);
        chk("t2_rsload_t_mask", 32'(ldt), 32'hF);
        chk("t2_taint_rules", 32'(bad), 32'd0);
        chk("t2_product", 32'(dp_rs[2*W-1:0]), 32'd15);
        chk("t2_product_t_nz", 32'(dp_pt != '0), 32'd1);

        // Tainted multiplier bit 2 only
        op_mr = 4'b0100; op_mr_t = 4'b0100;
        run_op(1'b0, lat, ndone, nadd, ld, ldt, bad);
        chk("t3_latency", 32'(lat), 32'd10);
        chk("t3_rsload_mask", 32'(ld), 32'h4);
        chk("t3_rsload_t_mask", 32'(ldt), 32'h4);
        chk("t3_taint_rules", 32'(bad), 32'd0);
        chk("t3_product", 32'(dp_rs[2*W-1:0]), 32'd12);

        // start held high: back-to-back, LOAD two cycles after done
        op_mr = 4'd5; op_mr_t = 4'd0;
        d1 = -1; d2 = -1; nld = 0; ld12 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.start_t = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (bus.mrld) nld++;
            if (c == 12) ld12 = bus.mrld;
            if (bus.done) begin
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
            end
        end
        bus.start = 1'b0;
        chk("b2b_first_done", 32'(d1), 32'd10);
        chk("b2b_load_at_done_plus2", 32'(ld12), 32'd1);
        chk("b2b_second_done", 32'(d2), 32'd21);
        chk("b2b_load_count", 32'(nld), 32'd2);
        repeat (3) @(negedge clk);
        chk("b2b_idle_after", 32'(bus.busy), 32'd0);

        // Reset during ADD with cnt=1
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs_clear", 32'(all_outs()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("rst_mid_no_done", 32'(ndone), 32'd0);
        run_op(1'b0, lat, ndone, nadd, ld, ldt, bad);
        chk("rst_mid_restart_latency", 32'(lat), 32'd10);
        chk("rst_mid_restart_product", 32'(dp_rs[2*W-1:0]), 32'd15);

`ifdef MULT_CTRL_ABORT_EN
        // Tainted abort in SHIFT with cnt=2
        @(negedge clk);
        bus.start = 1'b1; bus.start_t = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_in_shift", 32'(bus.rsshr), 32'd1);
        bus.abort = 1'b1; bus.abort_t = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.abort_t = 1'b0;
        chk("abort_idle_next", 32'(bus.busy), 32'd0);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(1'b1, lat, ndone, nadd, ld, ldt, bad);
        chk("abort_next_latency", 32'(lat), 32'd10);
        chk("abort_next_taint", 32'(bad), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000ns");
        $fatal(1);
    end
endmodule
